// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared defaults and FSM state type for the LIF timestep sequencer
package lif_pkg;

    localparam int unsigned LIF_POT_W     = 8;
    localparam int unsigned LIF_THRESHOLD = 100;
    localparam int unsigned LIF_LEAK      = 1;
    localparam int unsigned LIF_INCREMENT = 20;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } lif_state_t;

endpackage

// File: rtl/lif_update.sv
// rtl/lif_update.sv - combinational saturating LIF potential update and threshold compare
module lif_update
    import lif_pkg::*;
#(
    parameter int unsigned POT_W     = LIF_POT_W,
    parameter int unsigned THRESHOLD = LIF_THRESHOLD,
    parameter int unsigned LEAK      = LIF_LEAK,
    parameter int unsigned INCREMENT = LIF_INCREMENT
) (
    input  logic [POT_W-1:0] p,
    input  logic             pending,
    output logic [POT_W-1:0] p_next,
    output logic             fire
);

    // One bit of headroom above 32 so the add never wraps before saturation.
    localparam logic [32:0] MAX_P = 33'((33'd1 << POT_W) - 33'd1);

    logic [32:0] sum;
    logic [32:0] p1;
    logic [32:0] p2;

    // Add the spike increment saturating at full scale, then leak with a floor at zero.
    always_comb begin
        sum    = 33'(p) + (pending ? 33'(INCREMENT) : 33'd0);
        p1     = (sum > MAX_P) ? MAX_P : sum;
        p2     = (p1 > 33'(LEAK)) ? (p1 - 33'(LEAK)) : 33'd0;
        fire   = (p2 >= 33'(THRESHOLD));
        p_next = fire ? '0 : p2[POT_W-1:0];
    end

endmodule

// File: rtl/lif_timestep_sequencer.sv
// rtl/lif_timestep_sequencer.sv - time-multiplexed LIF neuron scan, one neuron per cycle per tick
module lif_timestep_sequencer
    import lif_pkg::*;
#(
    parameter int unsigned N_NEURONS = 8,
    parameter int unsigned POT_W     = LIF_POT_W,
    parameter int unsigned THRESHOLD = LIF_THRESHOLD,
    parameter int unsigned LEAK      = LIF_LEAK,
    parameter int unsigned INCREMENT = LIF_INCREMENT,
    localparam int unsigned IDX_W    = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 busy,
    output logic                 done,
    output logic                 spike_valid,
    output logic [IDX_W-1:0]     spike_idx,
    output logic                 overrun,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [POT_W-1:0]     rd_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    lif_state_t           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [POT_W-1:0]     pot_q [N_NEURONS];
    logic [N_NEURONS-1:0] pending_q;
    logic [N_NEURONS-1:0] clr_mask;
    logic                 eval;
    logic                 done_d;
    logic                 done_q;
    logic                 spike_valid_q;
    logic [IDX_W-1:0]     spike_idx_q;
    logic                 overrun_q;
    logic [POT_W-1:0]     rd_data_q;
    logic [POT_W-1:0]     p_next;
    logic                 fire;

    lif_update #(
        .POT_W     (POT_W),
        .THRESHOLD (THRESHOLD),
        .LEAK      (LEAK),
        .INCREMENT (INCREMENT)
    ) u_update (
        .p       (pot_q[idx_q]),
        .pending (pending_q[idx_q]),
        .p_next  (p_next),
        .fire    (fire)
    );

    // Next-state logic: IDLE waits for tick, SCAN walks idx 0..N-1 and pulses done on exit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        eval    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end
            end
            ST_SCAN: begin
                eval = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        clr_mask = eval ? (N_NEURONS'(1) << idx_q) : '0;
    end

    // FSM state and scan index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Potential array: only the neuron under evaluation is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                pot_q[i] <= '0;
            end
        end else if (eval) begin
            pot_q[idx_q] <= p_next;
        end
    end

    // Pending bits: the evaluated bit is consumed, but a spike in that same cycle re-arms it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask) | spike_in;
        end
    end

    // Registered status outputs, sticky overrun and the debug read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q        <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            overrun_q     <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            done_q        <= done_d;
            spike_valid_q <= eval & fire;
            if (eval && fire) begin
                spike_idx_q <= idx_q;
            end
            if (tick && (state_q == ST_SCAN)) begin
                overrun_q <= 1'b1;
            end
            rd_data_q <= (32'(rd_addr) < N_NEURONS) ? pot_q[rd_addr] : '0;
        end
    end

    assign busy        = (state_q == ST_SCAN);
    assign done        = done_q;
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign overrun     = overrun_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_lif_timestep_sequencer.sv
// tb/tb_lif_timestep_sequencer.sv - directed self-checking bench for lif_timestep_sequencer
module tb_lif_timestep_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] spike_in;
    logic       busy;
    logic       done;
    logic       spike_valid;
    logic [2:0] spike_idx;
    logic       overrun;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ts_fired;
    int         ts_fk [8];

    typedef struct {
        logic [7:0] pre;
        logic [2:0] addr;
        logic [7:0] pot;
        logic [7:0] fired;
    } vec_t;

    vec_t tbl [28];

    lif_timestep_sequencer #(
        .N_NEURONS (8),
        .POT_W     (8),
        .THRESHOLD (100),
        .LEAK      (1),
        .INCREMENT (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .spike_in    (spike_in),
        .busy        (busy),
        .done        (done),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx),
        .overrun     (overrun),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick  = 1'b0;
        @(negedge clk);
        check("busy_after_reset_tick", busy, 0);
    endtask

    // Tick in cycle t (with spike_in=pre), then observe cycles t+1..t+9; returns in cycle t+9.
    task automatic run_ts(input logic [7:0] pre, input int inj_k, input logic [7:0] inj_mask,
                          input int tick_k);
        ts_fired = '0;
        for (int i = 0; i < 8; i++) ts_fk[i] = 0;
        spike_in = pre;
        tick     = 1'b1;
        @(negedge clk);
        tick     = 1'b0;
        spike_in = '0;
        for (int k = 1; k <= 9; k++) begin
            check($sformatf("busy_k%0d", k), busy, (k <= 8) ? 1 : 0);
            check($sformatf("done_k%0d", k), done, (k == 9) ? 1 : 0);
            if (spike_valid) begin
                check("spike_once", ts_fired[spike_idx], 0);
                ts_fired[spike_idx] = 1'b1;
                ts_fk[spike_idx]    = k;
            end
            if (k < 9) begin
                spike_in = (k == inj_k) ? inj_mask : 8'h00;
                tick     = (k == tick_k);
                @(negedge clk);
            end
        end
        spike_in = '0;
        tick     = 1'b0;
    endtask

    task automatic check_fires(input logic [7:0] exp);
        check("fired_mask", ts_fired, exp);
        for (int i = 0; i < 8; i++) begin
            if (exp[i]) check($sformatf("fire_cycle_n%0d", i), ts_fk[i], i + 2);
        end
    endtask

    task automatic read_pot(input logic [2:0] a, input logic [7:0] exp, input string name);
        rd_addr = a;
        @(negedge clk);
        check(name, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        spike_in = '0;
        rd_addr  = '0;

        // Rows 0..5: neuron 0 charged every timestep, fires on the 6th.
        for (int r = 0; r < 5; r++) tbl[r] = '{8'h01, 3'd0, 8'(19 * (r + 1)), 8'h00};
        tbl[5] = '{8'h01, 3'd0, 8'd0, 8'h01};
        // Rows 6..20: neuron 3 charged once to 19 then leaks down to 5.
        tbl[6] = '{8'h08, 3'd3, 8'd19, 8'h00};
        for (int m = 0; m < 14; m++) tbl[7 + m] = '{8'h00, 3'd3, 8'(18 - m), 8'h00};
        // Rows 21..27: neuron 3 from 5 leaks to zero and stays there.
        tbl[21] = '{8'h00, 3'd3, 8'd4, 8'h00};
        tbl[22] = '{8'h00, 3'd3, 8'd3, 8'h00};
        tbl[23] = '{8'h00, 3'd3, 8'd2, 8'h00};
        tbl[24] = '{8'h00, 3'd3, 8'd1, 8'h00};
        tbl[25] = '{8'h00, 3'd3, 8'd0, 8'h00};
        tbl[26] = '{8'h00, 3'd3, 8'd0, 8'h00};
        tbl[27] = '{8'h00, 3'd3, 8'd0, 8'h00};

        do_reset();
        check("rst_done", done, 0);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_spike_idx", spike_idx, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_data", rd_data, 0);

        for (int r = 0; r < 28; r++) begin
            run_ts(tbl[r].pre, 0, 8'h00, 0);
            check_fires(tbl[r].fired);
            read_pot(tbl[r].addr, tbl[r].pot, $sformatf("pot_row%0d", r));
        end
        check("overrun_idle_ticks", overrun, 0);

        // Tick while busy is ignored and sets overrun; tick in the done cycle is accepted.
        do_reset();
        run_ts(8'h00, 0, 8'h00, 4);
        check("overrun_set", overrun, 1);
        run_ts(8'h00, 0, 8'h00, 0);
        check_fires(8'h00);
        check("overrun_sticky", overrun, 1);

        // Spike on neuron 2 in its own evaluation cycle is deferred to the next timestep.
        do_reset();
        run_ts(8'h00, 3, 8'h04, 0);
        read_pot(3'd2, 8'd0, "late_spike_deferred");
        run_ts(8'h00, 0, 8'h00, 0);
        read_pot(3'd2, 8'd19, "late_spike_counted");

        // Neurons 1 and 5 brought to 99, then both fire in one timestep.
        do_reset();
        for (int j = 0; j < 5; j++) run_ts(8'h22, 0, 8'h00, 0);
        read_pot(3'd5, 8'd95, "n5_at_95");
        for (int j = 0; j < 15; j++) run_ts(8'h00, 0, 8'h00, 0);
        read_pot(3'd1, 8'd80, "n1_at_80");
        run_ts(8'h22, 0, 8'h00, 0);
        check_fires(8'h00);
        read_pot(3'd1, 8'd99, "n1_at_99");
        read_pot(3'd5, 8'd99, "n5_at_99");
        run_ts(8'h22, 0, 8'h00, 0);
        check_fires(8'h22);
        read_pot(3'd1, 8'd0, "n1_after_fire");
        read_pot(3'd5, 8'd0, "n5_after_fire");

        // Reset in cycle t+4 of a scan aborts it without a done pulse.
        spike_in = 8'h01;
        tick     = 1'b1;
        @(negedge clk);                 // t+1
        tick     = 1'b0;
        spike_in = '0;
        @(negedge clk);                 // t+2
        rd_addr  = 3'd0;
        tick     = 1'b1;
        @(negedge clk);                 // t+3
        tick     = 1'b0;
        check("midscan_pot0", rd_data, 19);
        check("midscan_overrun", overrun, 1);
        check("midscan_spike_idx_held", spike_idx, 5);
        @(negedge clk);                 // t+4
        reset = 1'b1;
        @(negedge clk);                 // t+5
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_spike_valid", spike_valid, 0);
        check("abort_spike_idx", spike_idx, 0);
        check("abort_overrun", overrun, 0);
        check("abort_rd_data", rd_data, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("abort_no_done_%0d", k), done, 0);
            check($sformatf("abort_idle_%0d", k), busy, 0);
        end
        read_pot(3'd0, 8'd0, "abort_pot0");
        read_pot(3'd2, 8'd0, "abort_pot2");
        run_ts(8'h01, 0, 8'h00, 0);
        check_fires(8'h00);
        read_pot(3'd0, 8'd19, "post_abort_pot0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
